// File: rtl/tt_um_nibble_add_seq.sv
// tt_um_nibble_add_seq: nibble-serial 16-bit add/subtract sequencer.
// One shared 4-bit adder slice; the carry is registered between slices.
module tt_um_nibble_add_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    typedef enum logic [1:0] {IDLE, ACC, OUT_LO, OUT_HI} state_t;
    state_t state, state_nx;
    logic [1:0] k, k_nx, slice;
    logic c, c_nx, m, m_nx, flag, flag_nx;
    logic [15:0] r, r_nx;
    logic in_valid, out_ready, sub, abort, in_ready, out_valid, busy, mode, cin, unused;
    logic [4:0] sum;
    assign {abort, sub, out_ready, in_valid} = uio_in[3:0];
    assign unused = &{1'b0, uio_in[7:4]};
    assign in_ready = state == IDLE || state == ACC;
    assign out_valid = state == OUT_LO || state == OUT_HI;
    assign busy = state != IDLE;
    assign uo_out = state == OUT_LO ? r[7:0] : state == OUT_HI ? r[15:8] : 8'h00;
    assign uio_out = {flag, out_valid, in_ready, busy, 4'h0};
    assign uio_oe = 8'hF0;
    // The first nibble takes mode and carry-in straight from sub; later nibbles use the registers
    assign slice = state == IDLE ? 2'd0 : k;
    assign mode = state == IDLE ? sub : m;
    assign cin = state == IDLE ? sub : c;
    assign sum = {1'b0, ui_in[3:0]} + {1'b0, mode ? ~ui_in[7:4] : ui_in[7:4]} + {4'h0, cin};
    always_comb begin
        state_nx = state;
        k_nx = k;
        c_nx = c;
        m_nx = m;
        r_nx = r;
        flag_nx = flag;
        if (abort) begin
            state_nx = IDLE;
            k_nx = 2'd0;
            c_nx = 1'b0;
        end else begin
            case (state)
                IDLE, ACC: if (in_valid) begin
                    r_nx[{slice, 2'b00} +: 4] = sum[3:0];
                    c_nx = sum[4];
                    k_nx = slice + 2'd1;
                    state_nx = slice == 2'd3 ? OUT_LO : ACC;
                    m_nx = state == IDLE ? sub : m;
                    flag_nx = slice == 2'd3 ? sum[4] : state == IDLE ? 1'b0 : flag;
                end
                OUT_LO: state_nx = out_ready ? OUT_HI : state;
                default: state_nx = out_ready ? IDLE : state;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            k <= 2'd0;
            c <= 1'b0;
            m <= 1'b0;
            r <= 16'h0000;
            flag <= 1'b0;
        end else if (ena) begin
            state <= state_nx;
            k <= k_nx;
            c <= c_nx;
            m <= m_nx;
            r <= r_nx;
            flag <= flag_nx;
        end
    end
endmodule
